// File: rtl/bp_mem_interleave_splitter.sv
// Steers memory commands to one of N channels by address and returns responses in command order.
// Only channel IDs of in-flight commands are stored; command and response data pass straight through.
module bp_mem_interleave_splitter #(
   parameter int unsigned num_channels_p       = 2,
   parameter int unsigned paddr_width_p        = 40,
   parameter int unsigned data_width_p         = 128,
   parameter int unsigned block_offset_width_p = 6,
   parameter int unsigned range_lsb_p          = 28,
   parameter int unsigned interleave_mode_p    = 1,
   parameter int unsigned max_outstanding_p    = 8,
   localparam int unsigned CntW = $clog2(max_outstanding_p + 1)
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,

   input  logic [paddr_width_p-1:0]                 cmd_addr_i,
   input  logic [data_width_p-1:0]                  cmd_data_i,
   input  logic                                     cmd_v_i,
   output logic                                     cmd_ready_o,

   output logic [num_channels_p*paddr_width_p-1:0]  cmd_addr_o,
   output logic [num_channels_p*data_width_p-1:0]   cmd_data_o,
   output logic [num_channels_p-1:0]                cmd_v_o,
   input  logic [num_channels_p-1:0]                cmd_ready_i,

   input  logic [num_channels_p*data_width_p-1:0]   resp_data_i,
   input  logic [num_channels_p-1:0]                resp_v_i,
   output logic [num_channels_p-1:0]                resp_yumi_o,

   output logic [data_width_p-1:0]                  resp_data_o,
   output logic                                     resp_v_o,
   input  logic                                     resp_yumi_i,

   output logic [CntW-1:0]                          outstanding_o
);

   localparam int unsigned SelW = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
   localparam int unsigned PtrW = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
   localparam logic [PtrW-1:0] PtrLast = PtrW'(max_outstanding_p - 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(max_outstanding_p);

   logic [SelW-1:0] fifo_q [max_outstanding_p];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic [SelW-1:0] sel;
   logic [SelW-1:0] head;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;

   // ---------------------------------------------------------------------------
   // Channel select
   // ---------------------------------------------------------------------------
   always_comb begin
      sel = '0;
      if (num_channels_p > 1) begin
         if (interleave_mode_p != 0) begin
            sel = cmd_addr_i[block_offset_width_p +: SelW];
         end else begin
            sel = cmd_addr_i[range_lsb_p +: SelW];
         end
      end
   end

   assign full  = (count_q == CntMax);
   assign empty = (count_q == '0);
   assign head  = fifo_q[rd_ptr_q];

   // ---------------------------------------------------------------------------
   // Command path: broadcast address/data, one-hot valid
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < num_channels_p; g++) begin : gen_bcast
      assign cmd_addr_o[g*paddr_width_p +: paddr_width_p] = cmd_addr_i;
      assign cmd_data_o[g*data_width_p  +: data_width_p]  = cmd_data_i;
   end

   always_comb begin
      cmd_v_o     = '0;
      cmd_ready_o = 1'b0;
      for (int c = 0; c < num_channels_p; c++) begin
         if (sel == SelW'(c)) begin
            cmd_v_o[c]  = cmd_v_i & ~full;
            cmd_ready_o = cmd_ready_i[c] & ~full;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response path: only the FIFO head channel may be presented and consumed
   // ---------------------------------------------------------------------------
   always_comb begin
      resp_data_o = '0;
      resp_v_o    = 1'b0;
      resp_yumi_o = '0;
      for (int c = 0; c < num_channels_p; c++) begin
         if (head == SelW'(c)) begin
            resp_data_o    = resp_data_i[c*data_width_p +: data_width_p];
            resp_v_o       = ~empty & resp_v_i[c];
            resp_yumi_o[c] = ~empty & resp_yumi_i;
         end
      end
   end

   // Full uses the registered count only, so a same-cycle pop never opens a slot.
   assign push = cmd_v_i & cmd_ready_o;
   assign pop  = resp_yumi_i & resp_v_o;

   // ---------------------------------------------------------------------------
   // Tracking FIFO next state
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ID storage needs no reset: entries are only read while counted as occupied.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= sel;
      end
   end

   assign outstanding_o = count_q;

   // ---------------------------------------------------------------------------
   // Protocol checks
   // ---------------------------------------------------------------------------
   logic [num_channels_p-1:0] has_entry;

   always_comb begin
      int unsigned slot;
      slot      = 0;
      has_entry = '0;
      for (int k = 0; k < max_outstanding_p; k++) begin
         slot = int'(rd_ptr_q) + k;
         if (slot >= max_outstanding_p) begin
            slot = slot - max_outstanding_p;
         end
         if (k < int'(count_q)) begin
            for (int c = 0; c < num_channels_p; c++) begin
               if (fifo_q[PtrW'(slot)] == SelW'(c)) begin
                  has_entry[c] = 1'b1;
               end
            end
         end
      end
   end

   yumi_without_valid_a : assert property (
      @(posedge clk_i) disable iff (reset_i) resp_yumi_i |-> resp_v_o);

   stray_response_a : assert property (
      @(posedge clk_i) disable iff (reset_i) (resp_v_i & ~has_entry) == '0);

endmodule

// File: doc/bp_mem_interleave_splitter.md
Name: bp_mem_interleave_splitter

Overview:
Parametrised N-way successor to the fixed two-way DRAM command splitter that sits between a core's memory command port and its memory-network bridges. Steers each memory command to one of num_channels_p downstream channels, selected by address (cache-block interleave or contiguous range mode). Keeps an in-order tracking FIFO of issued channel IDs, so responses return to the core in command order even when channels answer out of order. Bounds total outstanding commands to max_outstanding_p.

Parameters:
num_channels_p, 2, number of downstream channels; power of two, 1..16
paddr_width_p, 40, physical address width
data_width_p, 128, command/response payload width excluding address
block_offset_width_p, 6, log2 interleave granularity in bytes (64 B blocks)
range_lsb_p, 28, lowest address bit of channel index in range mode
interleave_mode_p, 1, 1 = block interleave; 0 = range select
max_outstanding_p, 8, tracking FIFO depth = max commands in flight; >=2

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
cmd_addr_i  in  paddr_width_p  command address
cmd_data_i  in  data_width_p  command header+payload, passed through unchanged
cmd_v_i  in  1  command valid
cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o
cmd_addr_o  out  num_channels_p*paddr_width_p  per-channel address (broadcast)
cmd_data_o  out  num_channels_p*data_width_p  per-channel data (broadcast)
cmd_v_o  out  num_channels_p  per-channel valid, one-hot or zero
cmd_ready_i  in  num_channels_p  per-channel ready
resp_data_i  in  num_channels_p*data_width_p  per-channel response
resp_v_i  in  num_channels_p  per-channel response valid
resp_yumi_o  out  num_channels_p  per-channel response consume
resp_data_o  out  data_width_p  ordered response to core
resp_v_o  out  1  response valid
resp_yumi_i  in  1  core consumes response
outstanding_o  out  clog2(max_outstanding_p+1)  commands in flight

Behaviour:
- Channel select sel: mode 1 -> cmd_addr_i[block_offset_width_p +: lg(num_channels_p)]; mode 0 -> cmd_addr_i[range_lsb_p +: lg(num_channels_p)]. num_channels_p=1 -> sel=0.
- Command path combinational, zero latency: cmd_v_o[sel] = cmd_v_i & ~full; other bits 0. cmd_ready_o = cmd_ready_i[sel] & ~full.
- full = (count == max_outstanding_p). Full evaluated on registered count only; a same-cycle response dequeue does NOT free a slot for that cycle's command (no yumi->ready path).
- On accept: push sel into tracking FIFO; count++.
- Response path: head = FIFO head channel. resp_v_o = ~empty & resp_v_i[head]; resp_data_o = resp_data_i[head]; resp_yumi_o[head] = resp_yumi_i; other yumi bits 0. Valid responses on non-head channels held (not consumed) until their turn.
- On resp_yumi_i: pop FIFO; count--. Simultaneous accept and yumi: count unchanged, FIFO push and pop both occur.
- resp_yumi_i while resp_v_o=0 is illegal (assertion). resp_v_i[c] with no entry for c in FIFO flagged by assertion; no state change.
- Pointers wrap modulo max_outstanding_p (non-power-of-two depth supported).
- outstanding_o = count, registered.
- Reset (any cycle, incl. mid-traffic): FIFO pointers and count to 0; cmd_ready_o then equals cmd_ready_i[sel]; cmd_v_o=0 unless cmd_v_i; resp_v_o=0; resp_yumi_o=0; outstanding_o=0. In-flight tracking discarded; downstream channels reset alongside.
- No data storage; only channel IDs (lg(num_channels_p) bits x depth) are stored.

Test Plan:
- Interleave, 4 ch, 64 B blocks: cmds at 0x000,0x040,0x080,0x0C0,0x100 -> cmd_v_o one-hot 0001,0010,0100,1000,0001; outstanding_o=5.
- Out-of-order: issue to ch0 then ch1; ch1 responds first (data 0xB), ch0 two cycles later (0xA) -> resp_data_o 0xA then 0xB; resp_yumi_o[1] stays 0 until ch0 consumed.
- Full: depth 8, responses withheld, 9 cmds offered -> 8 accepted, cmd_ready_o=0 on 9th; yumi in same cycle still blocks; accepted next cycle, outstanding_o=8.
- Backpressure: cmd_ready_i[2]=0 with cmd to 0x080 -> cmd_ready_o=0, count unchanged; raise ready -> accepted same cycle.
- Range mode, range_lsb_p=28, 2 ch: 0x0FFF_FFC0 -> ch0, 0x1000_0000 -> ch1.
- Reset with 3 outstanding -> next cycle outstanding_o=0, resp_v_o=0, new cmd accepted immediately.
